leitor_placar: RTL and testbench

//  Receiving end of the scoreboard's multiplexed 7-segment display bus. It samples the segment lines and the two digit enables.
//  It decodes each digit back to BCD and debounces whole frames.

---
 rtl/leitor_placar_pkg.sv | 31 +++
 rtl/leitor_placar_seg7_decod.sv | 30 +++
 rtl/leitor_placar.sv | 161 ++++++++++++++++
 tb/tb_leitor_placar.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/leitor_placar_pkg.sv
// Shared definitions for the scoreboard display readback: segment codes, FSM states,
// and one reverse double-dabble step. Segment codes hold bit i = segment i (a = bit 0).
package leitor_placar_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_9ALT  = 7'h67;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam int CONV_STEPS = 7;

   typedef enum logic [1:0] {ACQ, CONV, PUB} state_e;

   // Work word is {bcd[7:0], bin[6:0]}: shift right, then pull each BCD nibble back below 8.
   function automatic logic [14:0] rdd_step(input logic [14:0] w);
      logic [14:0] s;
      s = w >> 1;
      if (s[14:11] >= 4'd8) s[14:11] = s[14:11] - 4'd3;
      if (s[10:7]  >= 4'd8) s[10:7]  = s[10:7]  - 4'd3;
      return s;
   endfunction

endpackage

// File: rtl/leitor_placar_seg7_decod.sv
// Combinational 7-segment to BCD decoder; a blank digit is only legal in the tens position.
module seg7_decod
   import leitor_placar_pkg::*;
(
   input  logic [6:0] seg_i,
   input  logic       is_tens_i,
   output logic [3:0] digit_o,
   output logic       invalid_o
);

   always_comb begin
      digit_o   = 4'd0;
      invalid_o = 1'b0;
      case (seg_i)
         SEG_0:           digit_o = 4'd0;
         SEG_1:           digit_o = 4'd1;
         SEG_2:           digit_o = 4'd2;
         SEG_3:           digit_o = 4'd3;
         SEG_4:           digit_o = 4'd4;
         SEG_5:           digit_o = 4'd5;
         SEG_6:           digit_o = 4'd6;
         SEG_7:           digit_o = 4'd7;
         SEG_8:           digit_o = 4'd8;
         SEG_9, SEG_9ALT: digit_o = 4'd9;
         SEG_BLANK:       invalid_o = ~is_tens_i;
         default:         invalid_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/leitor_placar.sv
// Reads the multiplexed 7-segment scoreboard back: captures settled digits, debounces
// whole frames and converts a newly stable score from BCD to binary.
module leitor_placar
   import leitor_placar_pkg::*;
#(
   parameter int SETTLE       = 2,
   parameter int MATCH_FRAMES = 2,
   parameter int TIMEOUT      = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] seg_in,
   input  logic [1:0] dig_en,
   input  logic       alerta_in,
   output logic [7:0] placar_bcd,
   output logic [6:0] placar_bin,
   output logic       alerta,
   output logic       valido,
   output logic       err_seg,
   output logic       lost
);

   localparam int SW = $clog2(SETTLE + 1);
   localparam int MW = $clog2(MATCH_FRAMES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [6:0]    seg_m_q, seg_s_q;
   logic [1:0]    en_m_q, en_s_q, en_prev_q;
   logic          al_m_q, al_s_q;
   logic [SW-1:0] settle_q;
   logic [TW-1:0] tmo_q;
   logic [3:0]    tens_q, units_q;
   logic          al_slot_q;
   logic [1:0]    filled_q, filled_d;
   logic [MW-1:0] match_q, match_d, match_next;
   logic [8:0]    prev_frame_q;
   logic          lost_q, err_q;

   state_e        state_q;
   logic [2:0]    step_q;
   logic [14:0]   work_q;
   logic [7:0]    conv_bcd_q, placar_bcd_q;
   logic          conv_al_q, alerta_q, valido_q, pub_any_q;
   logic [6:0]    placar_bin_q;

   logic          onehot, stable, capture, timeout_hit, frame_done, start_conv;
   logic [3:0]    dec_digit;
   logic          dec_invalid;
   logic [8:0]    frame;

   seg7_decod u_decod (
      .seg_i     (seg_s_q),
      .is_tens_i (en_s_q[0]),
      .digit_o   (dec_digit),
      .invalid_o (dec_invalid)
   );

   assign onehot      = (en_s_q == 2'b01) || (en_s_q == 2'b10);
   assign stable      = onehot && (en_s_q == en_prev_q);
   // settle_q saturates above SETTLE-1, so each enable interval captures once.
   assign capture     = stable && (settle_q == SW'(SETTLE - 1));
   assign timeout_hit = !capture && (tmo_q == TW'(TIMEOUT - 1));
   assign frame_done  = (filled_q == 2'b11);
   assign frame       = {tens_q, units_q, al_slot_q};
   assign match_next  = (frame != prev_frame_q)       ? MW'(1)  :
                        (match_q == MW'(MATCH_FRAMES)) ? match_q : match_q + MW'(1);
   assign start_conv  = frame_done && (state_q == ACQ) && (match_next >= MW'(MATCH_FRAMES)) &&
                        (!pub_any_q || (frame != {placar_bcd_q, alerta_q}));

   always_comb begin
      filled_d = filled_q;
      match_d  = match_q;
      if (frame_done) begin
         filled_d = 2'b00;
         match_d  = match_next;
      end
      if (capture) begin
         if (dec_invalid)    filled_d    = 2'b00;
         else if (en_s_q[0]) filled_d[0] = 1'b1;
         else                filled_d[1] = 1'b1;
      end
      if (timeout_hit) begin
         filled_d = 2'b00;
         match_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_m_q <= '0; seg_s_q <= '0;
         en_m_q <= '0; en_s_q <= '0; en_prev_q <= '0;
         al_m_q <= 1'b0; al_s_q <= 1'b0;
         settle_q <= '0; tmo_q <= '0;
         tens_q <= '0; units_q <= '0; al_slot_q <= 1'b0;
         filled_q <= '0; match_q <= '0; prev_frame_q <= '0;
         lost_q <= 1'b0; err_q <= 1'b0;
      end else begin
         seg_m_q   <= seg_in;    seg_s_q <= seg_m_q;
         en_m_q    <= dig_en;    en_s_q  <= en_m_q;
         al_m_q    <= alerta_in; al_s_q  <= al_m_q;
         en_prev_q <= en_s_q;
         settle_q  <= !stable ? '0 : (settle_q == SW'(SETTLE)) ? settle_q : settle_q + SW'(1);
         tmo_q     <= capture ? '0 : (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + TW'(1);
         if (capture)          lost_q <= 1'b0;
         else if (timeout_hit) lost_q <= 1'b1;
         if (capture && dec_invalid) err_q <= 1'b1;
         else if (state_q == PUB)    err_q <= 1'b0;
         if (capture && !dec_invalid) begin
            if (en_s_q[0]) tens_q  <= dec_digit;
            else           units_q <= dec_digit;
            al_slot_q <= al_s_q;
         end
         if (frame_done && !timeout_hit) prev_frame_q <= frame;
         filled_q <= filled_d;
         match_q  <= match_d;
      end
   end

   // Conversion works on a private copy, so captures may keep filling the slots meanwhile.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ACQ; step_q <= '0; work_q <= '0;
         conv_bcd_q <= '0; conv_al_q <= 1'b0;
         placar_bcd_q <= '0; placar_bin_q <= '0; alerta_q <= 1'b0;
         valido_q <= 1'b0; pub_any_q <= 1'b0;
      end else begin
         valido_q <= 1'b0;
         case (state_q)
            ACQ: if (start_conv) begin
               work_q     <= {tens_q, units_q, 7'd0};
               conv_bcd_q <= {tens_q, units_q};
               conv_al_q  <= al_slot_q;
               step_q     <= '0;
               state_q    <= CONV;
            end
            CONV: begin
               work_q <= rdd_step(work_q);
               if (step_q == 3'(CONV_STEPS - 1)) state_q <= PUB;
               else                              step_q  <= step_q + 3'd1;
            end
            PUB: begin
               placar_bcd_q <= conv_bcd_q;
               placar_bin_q <= work_q[6:0];
               alerta_q     <= conv_al_q;
               valido_q     <= 1'b1;
               pub_any_q    <= 1'b1;
               state_q      <= ACQ;
            end
            default: state_q <= ACQ;
         endcase
      end
   end

   assign placar_bcd = placar_bcd_q;
   assign placar_bin = placar_bin_q;
   assign alerta     = alerta_q;
   assign valido     = valido_q;
   assign err_seg    = err_q;
   assign lost       = lost_q;

endmodule

// File: tb/tb_leitor_placar.sv
// Directed bench for leitor_placar: drives display frames and compares the readback
// against hand-computed scores, pulse counts and the 9-clock publish latency.
module tb_leitor_placar;

   // Digit patterns written in a..g order, left to right.
   localparam logic [6:0] P0   = 7'b1111110;
   localparam logic [6:0] P2   = 7'b1101101;
   localparam logic [6:0] P4   = 7'b0110011;
   localparam logic [6:0] P7   = 7'b1110000;
   localparam logic [6:0] P9   = 7'b1111011;
   localparam logic [6:0] P9A  = 7'b1110011;
   localparam logic [6:0] PBLK = 7'b0000000;
   localparam logic [6:0] PBAD = 7'b0000001;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] seg_in = '0;
   logic [1:0] dig_en = '0;
   logic       alerta_in = 1'b0;
   logic [7:0] placar_bcd;
   logic [6:0] placar_bin;
   logic       alerta, valido, err_seg, lost;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int drive_cyc = 0;
   int v_count = 0;
   int v_cyc = -1;
   int u_cyc;

   leitor_placar dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seg_in     (seg_in),
      .dig_en     (dig_en),
      .alerta_in  (alerta_in),
      .placar_bcd (placar_bcd),
      .placar_bin (placar_bin),
      .alerta     (alerta),
      .valido     (valido),
      .err_seg    (err_seg),
      .lost       (lost)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valido) begin
         v_count <= v_count + 1;
         v_cyc   <= cyc;
      end
   end

   function automatic logic [6:0] abcdefg(input logic [6:0] s);
      logic [6:0] r;
      for (int i = 0; i < 7; i++) r[i] = s[6-i];
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic show(input logic [1:0] en, input logic [6:0] pat, input logic al, input int n);
      @(negedge clk);
      dig_en    = en;
      seg_in    = abcdefg(pat);
      alerta_in = al;
      drive_cyc = cyc;
      repeat (n - 1) @(negedge clk);
   endtask

   // Units capture lands 5 edges after the drive edge; valido follows 9 edges later.
   task automatic frame(input logic [6:0] t, input logic [6:0] u, input logic al);
      show(2'b01, t, al, 8);
      show(2'b10, u, al, 8);
      u_cyc = drive_cyc;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_bcd"},    placar_bcd, 0);
      check({tag, "_bin"},    placar_bin, 0);
      check({tag, "_alerta"}, alerta,     0);
      check({tag, "_valido"}, valido,     0);
      check({tag, "_err"},    err_seg,    0);
      check({tag, "_lost"},   lost,       0);
   endtask

   initial begin
      int u_first;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      // Score 42 appears after two identical frames
      frame(P4, P2, 1'b0);
      frame(P4, P2, 1'b0);
      u_first = u_cyc;
      frame(P4, P2, 1'b0);
      check("t1_bcd",    placar_bcd, 8'h42);
      check("t1_bin",    placar_bin, 42);
      check("t1_alerta", alerta,     0);
      check("t1_pulses", v_count,    1);
      check("t1_lat",    v_cyc,      u_first + 14);

      // A single 99 glitch frame must not publish
      frame(P9, P9, 1'b0);
      frame(P4, P2, 1'b0);
      frame(P4, P2, 1'b0);
      frame(P4, P2, 1'b0);
      check("t2_bcd",    placar_bcd, 8'h42);
      check("t2_bin",    placar_bin, 42);
      check("t2_pulses", v_count,    1);

      // 99 with overflow; second frame uses the alternate 9 shape
      frame(P9, P9, 1'b1);
      frame(P9A, P9A, 1'b1);
      u_first = u_cyc;
      frame(P9, P9A, 1'b1);
      check("t3_bcd",    placar_bcd, 8'h99);
      check("t3_bin",    placar_bin, 99);
      check("t3_alerta", alerta,     1);
      check("t3_pulses", v_count,    2);
      check("t3_lat",    v_cyc,      u_first + 14);

      // Invalid units pattern, then blank-tens 07 publishes and clears the error
      frame(P0, PBAD, 1'b0);
      check("t4_err_set", err_seg,    1);
      check("t4_hold",    placar_bcd, 8'h99);
      check("t4_pulses0", v_count,    2);
      frame(PBLK, P7, 1'b0);
      frame(PBLK, P7, 1'b0);
      frame(PBLK, P7, 1'b0);
      check("t4_bcd",     placar_bcd, 8'h07);
      check("t4_bin",     placar_bin, 7);
      check("t4_alerta",  alerta,     0);
      check("t4_err_clr", err_seg,    0);
      check("t4_pulses",  v_count,    3);

      // Overlap then gap: no captures, lost only after the timeout
      show(2'b11, P8_dummy(), 1'b0, 500);
      show(2'b00, PBLK, 1'b0, 400);
      check("t5_lost_early", lost, 0);
      show(2'b00, PBLK, 1'b0, 200);
      check("t5_lost",   lost,       1);
      check("t5_bcd",    placar_bcd, 8'h07);
      check("t5_pulses", v_count,    3);
      frame(PBLK, P7, 1'b0);
      check("t5_lost_clr", lost,    0);
      check("t5_pulses2",  v_count, 3);

      // Reset in the middle of a 42 conversion aborts it
      frame(P4, P2, 1'b0);
      frame(P4, P2, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_zero("t6_rst");
      frame(P4, P2, 1'b0);
      check("t6_no_pulse", v_count,    3);
      check("t6_bcd0",     placar_bcd, 0);
      frame(P4, P2, 1'b0);
      frame(P4, P2, 1'b0);
      check("t6_pulses", v_count,    4);
      check("t6_bcd",    placar_bcd, 8'h42);
      check("t6_bin",    placar_bin, 42);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   function automatic logic [6:0] P8_dummy();
      return 7'b1111111;
   endfunction

endmodule
